// File: rtl/dac_wave_seq.sv
// dac_wave_seq: per-tick waveform sequencer that writes a B/A code pair to a serial DAC controller.
// Ports: clk, rst_n; i_start/i_stop run control; i_mode/i_step waveform select;
//   i_dac_done handshake; o_dac_en/code/rs/spd/pwr request bundle; o_busy/o_overrun/o_err status.
module dac_wave_seq #(
    parameter int SAMPLE_DIV = 500,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [1:0]  i_mode,
    input  logic [11:0] i_step,
    input  logic        i_dac_done,
    output logic        o_dac_en,
    output logic [11:0] o_dac_code,
    output logic [1:0]  o_dac_rs,
    output logic        o_dac_spd,
    output logic        o_dac_pwr,
    output logic        o_busy,
    output logic        o_overrun,
    output logic        o_err
);

    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [15:0]   TO_LAST   = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        REQ_B,
        BUSY_B,
        REQ_A,
        BUSY_A
    } state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [15:0]   to_cnt;
    logic [11:0]   acc;
    logic          dir;
    logic          half;
    logic [11:0]   step_q;
    logic [1:0]    mode_q;
    logic [11:0]   code_a;
    logic [11:0]   code_b;
    logic          stop_q;

    logic          tick;
    logic [12:0]   up_sum;
    logic [11:0]   code_now;
    logic [11:0]   acc_nxt;
    logic          dir_nxt;
    logic          half_nxt;

    assign tick   = (state != IDLE) && (tick_cnt == TICK_LAST);
    assign up_sum = {1'b0, acc} + {1'b0, step_q};

    // Channel-A code taken from the waveform state at the tick.
    always_comb begin
        code_now = acc;
        unique case (i_mode)
            2'd0:    code_now = acc;
            2'd1:    code_now = acc;
            2'd2:    code_now = half ? 12'hfff : 12'h000;
            default: code_now = i_step;
        endcase
    end

    // Waveform advance, applied when the A write completes, using the
    // mode and step captured at the tick of this pair.
    always_comb begin
        acc_nxt  = acc;
        dir_nxt  = dir;
        half_nxt = half;
        unique case (mode_q)
            2'd0: acc_nxt = up_sum[11:0];
            2'd1: begin
                if (dir) begin
                    if (up_sum >= 13'd4095) begin
                        acc_nxt = 12'hfff;
                        dir_nxt = 1'b0;
                    end else begin
                        acc_nxt = up_sum[11:0];
                    end
                end else begin
                    if (acc <= step_q) begin
                        acc_nxt = 12'h000;
                        dir_nxt = 1'b1;
                    end else begin
                        acc_nxt = acc - step_q;
                    end
                end
            end
            2'd2: begin
                acc_nxt  = up_sum[11:0];
                half_nxt = half ^ up_sum[12];
            end
            default: acc_nxt = acc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            to_cnt     <= '0;
            acc        <= '0;
            dir        <= 1'b1;
            half       <= 1'b0;
            step_q     <= '0;
            mode_q     <= '0;
            code_a     <= '0;
            code_b     <= '0;
            stop_q     <= 1'b0;
            o_dac_en   <= 1'b0;
            o_dac_code <= '0;
            o_dac_rs   <= '0;
            o_dac_spd  <= 1'b1;
            o_dac_pwr  <= 1'b0;
            o_busy     <= 1'b0;
            o_overrun  <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_dac_en  <= 1'b0;
            o_dac_spd <= 1'b1;
            o_dac_pwr <= 1'b0;
            if (state != IDLE) begin
                tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            end
            // A tick is only consumed in WAIT_TICK; anywhere else it is lost.
            if (tick && state != WAIT_TICK) begin
                o_overrun <= 1'b1;
            end
            if (i_stop && state != IDLE) begin
                stop_q <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        state     <= WAIT_TICK;
                        o_busy    <= 1'b1;
                        o_overrun <= 1'b0;
                        o_err     <= 1'b0;
                        acc       <= '0;
                        dir       <= 1'b1;
                        half      <= 1'b0;
                        tick_cnt  <= '0;
                        stop_q    <= 1'b0;
                    end
                end
                WAIT_TICK: begin
                    if (i_stop) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else if (tick) begin
                        code_a <= code_now;
                        code_b <= ~code_now;
                        mode_q <= i_mode;
                        step_q <= i_step;
                        state  <= REQ_B;
                    end
                end
                REQ_B: begin
                    o_dac_en   <= 1'b1;
                    o_dac_code <= code_b;
                    o_dac_rs   <= 2'b01;
                    to_cnt     <= '0;
                    state      <= BUSY_B;
                end
                BUSY_B: begin
                    if (i_dac_done) begin
                        state <= REQ_A;
                    end else if (to_cnt == TO_LAST) begin
                        o_err  <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                REQ_A: begin
                    o_dac_en   <= 1'b1;
                    o_dac_code <= code_a;
                    o_dac_rs   <= 2'b10;
                    to_cnt     <= '0;
                    state      <= BUSY_A;
                end
                BUSY_A: begin
                    if (i_dac_done) begin
                        acc  <= acc_nxt;
                        dir  <= dir_nxt;
                        half <= half_nxt;
                        if (stop_q || i_stop) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            state <= WAIT_TICK;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        o_err  <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_wave_seq.sv
// tb_dac_wave_seq: self-checking bench for dac_wave_seq with a DAC done responder,
// a request monitor and an arithmetic waveform reference model.
module tb_dac_wave_seq;

    localparam int DIV  = 500;
    localparam int TO   = 255;
    localparam int DIV2 = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] step = 12'd0;
    logic        done = 1'b0;
    logic        en;
    logic [11:0] code;
    logic [1:0]  rs;
    logic        spd, pwr, busy, ovr, err;

    logic        start2 = 1'b0;
    logic        stop2 = 1'b0;
    logic        done2 = 1'b0;
    logic        en2;
    logic [11:0] code2;
    logic [1:0]  rs2;
    logic        spd2, pwr2, busy2, ovr2, err2;

    dac_wave_seq #(.SAMPLE_DIV(DIV), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_stop(stop),
        .i_mode(mode), .i_step(step), .i_dac_done(done),
        .o_dac_en(en), .o_dac_code(code), .o_dac_rs(rs),
        .o_dac_spd(spd), .o_dac_pwr(pwr), .o_busy(busy),
        .o_overrun(ovr), .o_err(err)
    );

    dac_wave_seq #(.SAMPLE_DIV(DIV2), .TIMEOUT(TO)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_start(start2), .i_stop(stop2),
        .i_mode(mode), .i_step(step), .i_dac_done(done2),
        .o_dac_en(en2), .o_dac_code(code2), .o_dac_rs(rs2),
        .o_dac_spd(spd2), .o_dac_pwr(pwr2), .o_busy(busy2),
        .o_overrun(ovr2), .o_err(err2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] code;
        logic [1:0]  rs;
        int          cyc;
    } xfer_t;

    xfer_t q[$];
    int    q2[$];
    xfer_t mon_x;
    int    lat = 180;
    int    lat2 = 80;
    bit    drop_a = 1'b0;
    int    vectors = 0;
    int    miscompares = 0;
    int    start_cyc = 0;

    int m_acc, m_dir, m_half;

    always @(negedge clk) begin
        if (en) begin
            mon_x.code = code;
            mon_x.rs   = rs;
            mon_x.cyc  = cyc;
            q.push_back(mon_x);
        end
        if (en2) q2.push_back(cyc);
    end

    initial begin
        forever begin
            @(negedge clk);
            if (en && !(drop_a && rs == 2'b10)) begin
                repeat (lat) @(negedge clk);
                done = 1'b1;
                @(negedge clk);
                done = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (en2) begin
                repeat (lat2) @(negedge clk);
                done2 = 1'b1;
                @(negedge clk);
                done2 = 1'b0;
            end
        end
    end

    // Reference waveform: plain integer arithmetic on the documented rules.
    task automatic model_reset();
        m_acc = 0; m_dir = 1; m_half = 0;
    endtask

    function automatic int model_code(int md, int st);
        if (md == 2) return m_half ? 4095 : 0;
        if (md == 3) return st;
        return m_acc;
    endfunction

    task automatic model_adv(int md, int st);
        if (md == 0) begin
            m_acc = (m_acc + st) % 4096;
        end else if (md == 1) begin
            if (m_dir == 1) begin
                if (m_acc + st >= 4095) begin m_acc = 4095; m_dir = 0; end
                else m_acc = m_acc + st;
            end else begin
                if (m_acc <= st) begin m_acc = 0; m_dir = 1; end
                else m_acc = m_acc - st;
            end
        end else if (md == 2) begin
            if (m_acc + st >= 4096) m_half = 1 - m_half;
            m_acc = (m_acc + st) % 4096;
        end
    endtask

    task automatic wait_until(int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_q(input int n, input int budget, output bit ok);
        int k = 0;
        while (q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (q.size() >= n);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stop_idle(output bit ok);
        int k = 0;
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        while (busy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        ok = !busy;
    endtask

    task automatic run_pairs(input int n, output bit ok);
        bit ok2;
        q.delete();
        pulse_start();
        wait_q(2 * n, (n + 2) * DIV, ok);
        stop_idle(ok2);
        ok = ok && ok2;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({en, code, rs, spd, pwr, busy, ovr, err} !== {1'b0, 12'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got en=%b code=%h rs=%b spd=%b pwr=%b busy=%b ovr=%b err=%b, want 0 000 00 1 0 0 0 0",
                     en, code, rs, spd, pwr, busy, ovr, err);
        end
        vectors++;
        if ({en2, busy2, ovr2, err2, spd2, pwr2} !== 6'b000010) begin
            miscompares++;
            $display("FAIL reset_state2: got %b want 000010", {en2, busy2, ovr2, err2, spd2, pwr2});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sawtooth();
        bit ok;
        int expa[5];
        expa = '{0, 1024, 2048, 3072, 0};
        lat = 180; mode = 2'd0; step = 12'd1024;
        run_pairs(5, ok);
        vectors++;
        if (!ok || q.size() != 10) begin
            miscompares++;
            $display("FAIL saw_count: got %0d requests ok=%0d, want 10", q.size(), ok);
        end
        for (int i = 0; i < 5 && 2 * i + 1 < q.size(); i++) begin
            vectors++;
            if (q[2*i].code !== 12'(4095 - expa[i]) || q[2*i].rs !== 2'b01) begin
                miscompares++;
                $display("FAIL saw_b%0d: got code=%0d rs=%b, want %0d 01", i, q[2*i].code, q[2*i].rs, 4095 - expa[i]);
            end
            vectors++;
            if (q[2*i+1].code !== 12'(expa[i]) || q[2*i+1].rs !== 2'b10) begin
                miscompares++;
                $display("FAIL saw_a%0d: got code=%0d rs=%b, want %0d 10", i, q[2*i+1].code, q[2*i+1].rs, expa[i]);
            end
            vectors++;
            if (q[2*i+1].cyc - q[2*i].cyc != lat + 2) begin
                miscompares++;
                $display("FAIL saw_done_to_a%0d: got %0d cycles, want %0d", i, q[2*i+1].cyc - q[2*i].cyc, lat + 2);
            end
            if (i > 0) begin
                vectors++;
                if (q[2*i].cyc - q[2*i-2].cyc != DIV) begin
                    miscompares++;
                    $display("FAIL saw_tick_period%0d: got %0d, want %0d", i, q[2*i].cyc - q[2*i-2].cyc, DIV);
                end
            end
        end
        if (q.size() > 0) begin
            vectors++;
            if (q[0].cyc - start_cyc != DIV + 2) begin
                miscompares++;
                $display("FAIL saw_first_b: got %0d cycles after start, want %0d", q[0].cyc - start_cyc, DIV + 2);
            end
        end
    endtask

    task automatic test_triangle();
        bit ok;
        int expa[8];
        expa = '{0, 1500, 3000, 4095, 2595, 1095, 0, 1500};
        lat = 150; mode = 2'd1; step = 12'd1500;
        run_pairs(8, ok);
        vectors++;
        if (!ok || q.size() != 16) begin
            miscompares++;
            $display("FAIL tri_count: got %0d requests, want 16", q.size());
        end
        for (int i = 0; i < 8 && 2 * i + 1 < q.size(); i++) begin
            vectors++;
            if (q[2*i+1].code !== 12'(expa[i]) || q[2*i].code !== 12'(4095 - expa[i])) begin
                miscompares++;
                $display("FAIL tri_pair%0d: got a=%0d b=%0d, want a=%0d b=%0d",
                         i, q[2*i+1].code, q[2*i].code, expa[i], 4095 - expa[i]);
            end
        end
    endtask

    task automatic test_square_dc();
        bit ok, ok2;
        int expa[5];
        expa = '{0, 0, 4095, 4095, 0};
        lat = 120; mode = 2'd2; step = 12'd2048;
        q.delete();
        pulse_start();
        wait_q(10, 7 * DIV, ok);
        mode = 2'd3; step = 12'h5a5;
        wait_q(12, 3 * DIV, ok2);
        vectors++;
        if (!(ok && ok2)) begin
            miscompares++;
            $display("FAIL sq_count: got %0d requests, want 12", q.size());
        end
        for (int i = 0; i < 5 && 2 * i + 1 < q.size(); i++) begin
            vectors++;
            if (q[2*i+1].code !== 12'(expa[i])) begin
                miscompares++;
                $display("FAIL sq_a%0d: got %0d, want %0d", i, q[2*i+1].code, expa[i]);
            end
        end
        if (q.size() >= 12) begin
            vectors++;
            if (q[11].code !== 12'h5a5 || q[10].code !== 12'ha5a) begin
                miscompares++;
                $display("FAIL dc_pair: got a=%h b=%h, want 5a5 a5a", q[11].code, q[10].code);
            end
        end
        stop_idle(ok);
    endtask

    task automatic test_random();
        bit ok;
        int md, st, n, ea;
        n = 6;
        for (int r = 0; r < 3; r++) begin
            md = int'($urandom_range(0, 2));
            st = int'($urandom_range(1, 4095));
            lat = int'($urandom_range(10, 200));
            mode = 2'(md); step = 12'(st);
            model_reset();
            run_pairs(n, ok);
            vectors++;
            if (!ok || q.size() != 2 * n) begin
                miscompares++;
                $display("FAIL rnd%0d_count: got %0d, want %0d", r, q.size(), 2 * n);
            end
            for (int i = 0; i < n && 2 * i + 1 < q.size(); i++) begin
                ea = model_code(md, st);
                vectors++;
                if (q[2*i+1].code !== 12'(ea) || q[2*i].code !== 12'(4095 - ea) ||
                    q[2*i].rs !== 2'b01 || q[2*i+1].rs !== 2'b10) begin
                    miscompares++;
                    $display("FAIL rnd%0d_pair%0d mode=%0d step=%0d: got a=%0d b=%0d, want a=%0d b=%0d",
                             r, i, md, st, q[2*i+1].code, q[2*i].code, ea, 4095 - ea);
                end
                model_adv(md, st);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int ea;
        lat = 100; mode = 2'd0; step = 12'd100;
        drop_a = 1'b1;
        q.delete();
        pulse_start();
        wait_q(2, 3 * DIV, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL to_req_a: got %0d requests, want 2", q.size());
        end else begin
            ea = q[1].cyc;
            wait_until(ea + TO - 1);
            vectors++;
            if (err !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL to_early: got err=%b busy=%b, want 0 1", err, busy);
            end
            wait_until(ea + TO);
            vectors++;
            if (err !== 1'b1 || busy !== 1'b0 || en !== 1'b0) begin
                miscompares++;
                $display("FAIL to_fire: got err=%b busy=%b en=%b, want 1 0 0", err, busy, en);
            end
            repeat (2 * DIV) @(negedge clk);
            vectors++;
            if (q.size() != 2) begin
                miscompares++;
                $display("FAIL to_no_more_en: got %0d requests, want 2", q.size());
            end
        end
        drop_a = 1'b0;
        repeat (300) @(negedge clk);
        pulse_start();
        vectors++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL to_restart_clear: got err=%b busy=%b, want 0 1", err, busy);
        end
        stop_idle(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL to_stop_wait: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_overrun();
        int k, e0;
        mode = 2'd0; step = 12'd50;
        q2.delete();
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        k = 0;
        while (q2.size() < 1 && k < 4 * DIV2) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (q2.size() < 1) begin
            miscompares++;
            $display("FAIL ovr_first_b: got no request, want one");
        end else begin
            e0 = q2[0];
            wait_until(e0 + 98);
            vectors++;
            if (ovr2 !== 1'b0) begin
                miscompares++;
                $display("FAIL ovr_early: got %b, want 0", ovr2);
            end
            wait_until(e0 + 99);
            vectors++;
            if (ovr2 !== 1'b1) begin
                miscompares++;
                $display("FAIL ovr_set: got %b, want 1", ovr2);
            end
            wait_until(e0 + 590);
            vectors++;
            if (q2.size() != 6) begin
                miscompares++;
                $display("FAIL ovr_en_count: got %0d, want 6", q2.size());
            end else begin
                vectors++;
                if (q2[1] - q2[0] != lat2 + 2 || q2[2] - q2[0] != 2 * DIV2 || q2[4] - q2[2] != 2 * DIV2) begin
                    miscompares++;
                    $display("FAIL ovr_spacing: got %0d %0d %0d, want %0d %0d %0d",
                             q2[1] - q2[0], q2[2] - q2[0], q2[4] - q2[2], lat2 + 2, 2 * DIV2, 2 * DIV2);
                end
            end
        end
        @(negedge clk);
        stop2 = 1'b1;
        @(negedge clk);
        stop2 = 1'b0;
        repeat (300) @(negedge clk);
        vectors++;
        if (busy2 !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_stop: got busy=%b, want 0", busy2);
        end
    endtask

    task automatic test_stop();
        bit ok;
        int ea;
        lat = 180; mode = 2'd0; step = 12'd7;
        q.delete();
        pulse_start();
        wait_q(1, 3 * DIV, ok);
        repeat (10) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_q(2, 2 * DIV, ok);
        vectors++;
        if (!ok || q[1].rs !== 2'b10) begin
            miscompares++;
            $display("FAIL stop_a_write: got %0d requests, want A write after stop", q.size());
        end else begin
            ea = q[1].cyc;
            wait_until(ea + lat);
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL stop_busy_hold: got %b, want 1", busy);
            end
            wait_until(ea + lat + 1);
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL stop_idle: got %b, want 0", busy);
            end
            repeat (2 * DIV) @(negedge clk);
            vectors++;
            if (q.size() != 2) begin
                miscompares++;
                $display("FAIL stop_no_more_en: got %0d requests, want 2", q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        lat = 180; mode = 2'd3; step = 12'h123;
        q.delete();
        pulse_start();
        wait_q(2, 3 * DIV, ok);
        if (ok) wait_until(q[1].cyc + 20);
        vectors++;
        if (busy !== 1'b1 || code !== 12'h123) begin
            miscompares++;
            $display("FAIL rstmid_pre: got busy=%b code=%h, want 1 123", busy, code);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({en, code, rs, spd, pwr, busy, ovr, err} !== {1'b0, 12'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got en=%b code=%h rs=%b spd=%b pwr=%b busy=%b ovr=%b err=%b, want 0 000 00 1 0 0 0 0",
                     en, code, rs, spd, pwr, busy, ovr, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (250) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || q.size() != 2) begin
            miscompares++;
            $display("FAIL rstmid_after: got busy=%b requests=%0d, want 0 2", busy, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_sawtooth();
        test_triangle();
        test_square_dc();
        test_random();
        test_timeout();
        test_overrun();
        test_stop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
